vga_timing_monitor: RTL

- Receive-side counterpart of the VGA sync/timing generators. Watches hsync, vsync and dataValid, all in the pixelClk domain.
- Measures line length and frame height, and locks when timing matches the 800x525 total (640x480 active) format.
- Produces active-pixel coordinates and a single-cycle error pulse.
- Sits between the timing generators and downstream pixel consumers (framebuffer reader, pattern checker).

---
 rtl/vga_timing_monitor.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: measures line/frame periods from hsync/vsync
// falls, locks after consecutive good frames, and reports active-pixel coordinates.
`timescale 1ns/1ps
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        pixelClk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        dataValid,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic [10:0] lineLen,
  output logic [9:0]  frameLines,
  output logic        locked,
  output logic        frameStart,
  output logic        timingErr
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

  logic          hsync_prev;
  logic          vsync_prev;
  logic [10:0]   h_count;
  logic [9:0]    v_count;
  logic [1:0]    state;
  logic [GW-1:0] good_frames;
  logic          line_valid;
  logic          frame_bad;
  logic          line_had_dv;

  logic          h_fall;
  logic          v_fall;
  logic [11:0]   line_len_new;
  logic [10:0]   frame_lines_new;
  logic          line_bad;
  logic          frame_len_ok;
  logic [GW:0]   good_inc;

  always_comb begin
    h_fall          = hsync_prev & ~hsync;
    v_fall          = vsync_prev & ~vsync;
    line_len_new    = {1'b0, h_count} + 12'd1;
    frame_lines_new = {1'b0, v_count} + {10'd0, h_fall};
    // A line is bad on a wrong-length hsync period, or once when hsync goes missing
    // long enough for the line counter to hit its ceiling.
    line_bad        = line_valid &
                      ((h_fall & (line_len_new != 12'(H_TOTAL))) |
                       (~h_fall & (h_count == 11'd2046)));
    frame_len_ok    = (frame_lines_new == 11'(V_TOTAL));
    good_inc        = {1'b0, good_frames} + (GW+1)'(1);
  end

  always_ff @(posedge pixelClk or negedge rst) begin
    if (!rst) begin
      hsync_prev  <= 1'b1;
      vsync_prev  <= 1'b1;
      h_count     <= '0;
      v_count     <= '0;
      pixelX      <= '0;
      pixelY      <= '0;
      lineLen     <= '0;
      frameLines  <= '0;
      locked      <= 1'b0;
      frameStart  <= 1'b0;
      timingErr   <= 1'b0;
      state       <= SEARCH;
      good_frames <= '0;
      line_valid  <= 1'b0;
      frame_bad   <= 1'b0;
      line_had_dv <= 1'b0;
    end else begin
      hsync_prev <= hsync;
      vsync_prev <= vsync;
      frameStart <= v_fall;
      timingErr  <= 1'b0;
      locked     <= (state == LOCKED);

      if (h_fall) begin
        lineLen    <= line_len_new[10:0];
        h_count    <= '0;
        line_valid <= 1'b1;
      end else if (h_count != '1) begin
        h_count <= h_count + 11'd1;
      end

      if (v_fall) begin
        frameLines <= frame_lines_new[9:0];
        v_count    <= '0;
      end else if (h_fall && (v_count != '1)) begin
        v_count <= v_count + 10'd1;
      end

      if (h_fall)         pixelX <= '0;
      else if (dataValid) pixelX <= pixelX + 10'd1;

      if (h_fall)         line_had_dv <= 1'b0;
      else if (dataValid) line_had_dv <= 1'b1;

      if (v_fall)                               pixelY <= '0;
      else if (h_fall && (line_had_dv | dataValid)) pixelY <= pixelY + 10'd1;

      case (state)
        SEARCH: begin
          if (v_fall) begin
            state       <= ACQUIRE;
            good_frames <= '0;
            frame_bad   <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (v_fall) begin
            frame_bad <= 1'b0;
            // A bad line coinciding with the vsync fall still spoils this frame.
            if (!frame_bad && !line_bad && frame_len_ok) begin
              if (good_inc == (GW+1)'(LOCK_FRAMES)) begin
                state       <= LOCKED;
                good_frames <= '0;
              end else begin
                good_frames <= good_inc[GW-1:0];
              end
            end else begin
              good_frames <= '0;
            end
          end else if (line_bad) begin
            frame_bad <= 1'b1;
          end
        end
        LOCKED: begin
          if (line_bad || (v_fall && !frame_len_ok)) begin
            timingErr  <= 1'b1;
            state      <= SEARCH;
            line_valid <= 1'b0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
